// File: rtl/foo_accum_sched.sv
// Round-robin front end for a shared 64-bit accumulator (next = accum + a + 1).
// Operands are pre-compensated so grants add exactly the requested value, idle cycles hold, clears zero.
module foo_accum_sched #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int CNT_W   = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [64*NUM_REQ-1:0]   req_data,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic                    clr_req,
  output logic                    clr_ack,
  output logic [63:0]             accum_a,
  input  logic [63:0]             accum_x,
  output logic                    resp_valid,
  output logic [ID_W-1:0]         resp_id,
  output logic [63:0]             resp_data,
  output logic [CNT_W-1:0]        op_count
);

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_CLR_DONE = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic              armed_q, armed_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic              resp_valid_q, resp_valid_d;
  logic [ID_W-1:0]   resp_id_q, resp_id_d;
  logic [CNT_W-1:0]  op_count_q, op_count_d;

  logic              grant_vld;
  logic [ID_W-1:0]   grant_id;
  logic              do_clr;
  logic              grant;
  logic [63:0]       grant_data;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Round-robin search starting one past the last winner
  always_comb begin
    int              idx;
    logic [ID_W-1:0] cand;
    grant_vld = 1'b0;
    grant_id  = '0;
    idx       = 0;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      cand = ID_W'(idx);
      if (!grant_vld && req_valid[cand]) begin
        grant_vld = 1'b1;
        grant_id  = cand;
      end
    end
  end

  always_comb begin
    grant_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id == ID_W'(i)) grant_data = req_data[64*i +: 64];
    end
  end

  // rst_n gates the operand so the accumulator holds while reset is asserted
  always_comb begin
    state_d      = ST_RUN;
    armed_d      = armed_q;
    ptr_d        = ptr_q;
    resp_valid_d = 1'b0;
    resp_id_d    = resp_id_q;
    op_count_d   = op_count_q;
    req_ready    = '0;
    accum_a      = '1;

    do_clr = rst_n && (state_q == ST_RUN) && clr_req && armed_q;
    grant  = rst_n && !do_clr && grant_vld;

    if (!clr_req) begin
      armed_d = 1'b1;
    end else if (do_clr) begin
      armed_d = 1'b0;
    end

    if (do_clr) begin
      state_d = ST_CLR_DONE;
      accum_a = ~accum_x;
    end else if (grant) begin
      req_ready[grant_id] = 1'b1;
      accum_a             = grant_data - 64'd1;
      ptr_d               = grant_id;
      resp_valid_d        = 1'b1;
      resp_id_d           = grant_id;
      op_count_d          = sat_inc(op_count_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_RUN;
      armed_q      <= 1'b1;
      ptr_q        <= ID_W'(NUM_REQ - 1);
      resp_valid_q <= 1'b0;
      resp_id_q    <= '0;
      op_count_q   <= '0;
    end else begin
      state_q      <= state_d;
      armed_q      <= armed_d;
      ptr_q        <= ptr_d;
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
      op_count_q   <= op_count_d;
    end
  end

  assign clr_ack    = (state_q == ST_CLR_DONE);
  assign resp_valid = resp_valid_q;
  assign resp_id    = resp_id_q;
  assign resp_data  = accum_x;
  assign op_count   = op_count_q;

endmodule

// File: tb/tb_foo_accum_sched.sv
// Bench for foo_accum_sched: models the external accumulator and checks every cycle
// against a cycle-level reference of the scheduling rules.
module tb_foo_accum_sched;
  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic                  clk;
  logic                  rst_n;
  logic [NUM_REQ-1:0]    req_valid;
  logic [64*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]    req_ready;
  logic                  clr_req;
  logic                  clr_ack;
  logic [63:0]           accum_a;
  logic [63:0]           accum_x;
  logic                  resp_valid;
  logic [ID_W-1:0]       resp_id;
  logic [63:0]           resp_data;
  logic [CNT_W-1:0]      op_count;

  logic [63:0] acc;
  logic        acc_init;

  int vectors     = 0;
  int miscompares = 0;

  // reference model state (m_*) and its value after the current cycle (n_*)
  logic [63:0] m_acc, n_acc;
  int          m_ptr, n_ptr, m_cnt, n_cnt, m_rid, n_rid;
  bit          m_rv, n_rv, m_ack, n_ack, m_armed, n_armed;

  logic [NUM_REQ-1:0] e_ready;
  logic [63:0]        e_a, e_x;
  logic               e_rv, e_ack;
  logic [ID_W-1:0]    e_rid;
  logic [CNT_W-1:0]   e_cnt;
  int                 e_win;

  foo_accum_sched #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .clr_req(clr_req), .clr_ack(clr_ack),
    .accum_a(accum_a), .accum_x(accum_x),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_data(resp_data),
    .op_count(op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // the shared accumulator datapath: no enable, no clear
  always @(posedge clk) acc <= acc_init ? 64'd0 : acc + accum_a + 64'd1;
  assign accum_x = acc;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [64*NUM_REQ-1:0] pack4(input logic [63:0] d0, d1, d2, d3);
    return {d3, d2, d1, d0};
  endfunction

  function automatic logic [63:0] rnd64();
    case ($urandom % 8)
      0:       return 64'd0;
      1:       return '1;
      2:       return 64'($urandom % 16);
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic model_reset();
    m_ptr = NUM_REQ - 1; m_cnt = 0; m_rid = 0;
    m_rv = 0; m_ack = 0; m_armed = 1;
  endtask

  // Apply inputs just after a rising edge, predict this cycle, then wait for the falling edge
  task automatic drive(input logic [NUM_REQ-1:0] v, input logic [64*NUM_REQ-1:0] d, input logic clr);
    bit          do_clr;
    logic [63:0] wd;
    int          idx;
    req_valid = v; req_data = d; clr_req = clr;
    e_rv = m_rv; e_rid = ID_W'(m_rid); e_ack = m_ack; e_cnt = CNT_W'(m_cnt); e_x = m_acc;
    do_clr = clr && m_armed && !m_ack;
    e_win = -1;
    if (!do_clr) begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        idx = (m_ptr + k) % NUM_REQ;
        if (e_win < 0 && ((v >> idx) & NUM_REQ'(1)) != 0) e_win = idx;
      end
    end
    e_ready = '0; wd = '0;
    if (e_win >= 0) begin
      e_ready = NUM_REQ'(1) << e_win;
      wd      = 64'(d >> (64 * e_win));
    end
    e_a     = do_clr ? ~m_acc : (e_win >= 0) ? wd - 64'd1 : '1;
    n_acc   = do_clr ? 64'd0 : m_acc + wd;
    n_armed = !clr ? 1'b1 : (do_clr ? 1'b0 : m_armed);
    n_ack   = do_clr;
    n_rv    = (e_win >= 0);
    n_rid   = (e_win >= 0) ? e_win : 0;
    n_ptr   = (e_win >= 0) ? e_win : m_ptr;
    n_cnt   = (e_win >= 0 && m_cnt < CNT_MAX) ? m_cnt + 1 : m_cnt;
    @(negedge clk);
  endtask

  task automatic commit();
    @(posedge clk);
    #1;
    m_acc = n_acc; m_armed = n_armed; m_ack = n_ack;
    m_rv = n_rv; m_rid = n_rid; m_ptr = n_ptr; m_cnt = n_cnt;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; acc_init = 1'b1; req_valid = '0; req_data = '0; clr_req = 1'b0;
    m_acc = 64'd0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 acc_init = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req_valid = NUM_REQ'($urandom); req_data = pack4(rnd64(), rnd64(), rnd64(), rnd64());
      clr_req = 1'($urandom);
      @(negedge clk);
      vectors++;
      if (req_ready !== '0 || accum_a !== '1 || resp_valid !== 1'b0 || resp_id !== '0 ||
          clr_ack !== 1'b0 || op_count !== '0 || accum_x !== 64'd0) begin
        miscompares++;
        $display("FAIL reset %0d: rdy=%b a=%h rv=%b id=%0d ack=%b cnt=%0d x=%h, expected rdy=0 a=all-ones rv=0 id=0 ack=0 cnt=0 x=0",
                 i, req_ready, accum_a, resp_valid, resp_id, clr_ack, op_count, accum_x);
      end
      @(posedge clk);
      #1;
    end
    rst_n = 1'b1; req_valid = '0; clr_req = 1'b0;
  endtask

  task automatic test_single();
    drive(4'b0001, pack4(64'd5, 64'd9, 64'd9, 64'd9), 1'b0);
    vectors++;
    if (accum_a !== 64'd4 || req_ready !== 4'b0001 || accum_a !== e_a) begin
      miscompares++;
      $display("FAIL single_grant: rdy=%b a=%h, expected rdy=0001 a=%h", req_ready, accum_a, 64'd4);
    end
    commit();
    drive(4'b0000, '0, 1'b0);
    vectors++;
    if (resp_valid !== 1'b1 || resp_id !== 2'd0 || resp_data !== 64'd5 || op_count !== 4'd1 ||
        accum_a !== e_a || clr_ack !== e_ack) begin
      miscompares++;
      $display("FAIL single_resp: rv=%b id=%0d rd=%h cnt=%0d a=%h, expected rv=1 id=0 rd=5 cnt=1 a=%h",
               resp_valid, resp_id, resp_data, op_count, accum_a, e_a);
    end
    commit();
  endtask

  task automatic test_round_robin();
    logic [63:0] sums [8];
    sums = '{64'd1, 64'd3, 64'd6, 64'd10, 64'd11, 64'd13, 64'd16, 64'd20};
    // fresh pointer and a zeroed accumulator
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
    drive('0, '0, 1'b1); commit();
    drive('0, '0, 1'b0); commit();
    for (int i = 0; i <= 8; i++) begin
      if (i < 8) drive('1, pack4(64'd1, 64'd2, 64'd3, 64'd4), 1'b0);
      else       drive('0, '0, 1'b0);
      vectors++;
      if (req_ready !== e_ready || accum_a !== e_a || resp_valid !== e_rv || clr_ack !== e_ack ||
          op_count !== e_cnt || accum_x !== e_x || (e_rv && (resp_id !== e_rid || resp_data !== e_x))) begin
        miscompares++;
        $display("FAIL round_robin %0d: rdy=%b a=%h rv=%b id=%0d rd=%h ack=%b cnt=%0d x=%h, expected rdy=%b a=%h rv=%b id=%0d rd=%h ack=%b cnt=%0d x=%h",
                 i, req_ready, accum_a, resp_valid, resp_id, resp_data, clr_ack, op_count, accum_x,
                 e_ready, e_a, e_rv, e_rid, e_x, e_ack, e_cnt, e_x);
      end
      vectors++;
      if ((i < 8 && req_ready !== (NUM_REQ'(1) << (i % NUM_REQ))) ||
          (i > 0 && (resp_data !== sums[i-1] || resp_id !== ID_W'((i - 1) % NUM_REQ)))) begin
        miscompares++;
        $display("FAIL rr_order %0d: rdy=%b id=%0d rd=%0d, expected grant %0d and rd=%0d",
                 i, req_ready, resp_id, resp_data, i % NUM_REQ, (i > 0) ? sums[i-1] : 64'd0);
      end
      commit();
    end
  endtask

  task automatic test_idle();
    for (int i = 0; i < 10; i++) begin
      drive('0, pack4(rnd64(), rnd64(), rnd64(), rnd64()), 1'b0);
      vectors++;
      if (accum_a !== '1 || accum_x !== 64'd20 || resp_valid !== 1'b0 || req_ready !== '0 ||
          op_count !== e_cnt || clr_ack !== 1'b0) begin
        miscompares++;
        $display("FAIL idle %0d: a=%h x=%0d rv=%b rdy=%b cnt=%0d ack=%b, expected a=all-ones x=20 rv=0 rdy=0 cnt=%0d ack=0",
                 i, accum_a, accum_x, resp_valid, req_ready, op_count, clr_ack, e_cnt);
      end
      commit();
    end
  endtask

  task automatic test_clear();
    int acks;
    acks = 0;
    for (int i = 0; i < 5; i++) begin
      drive((i < 2) ? 4'b0100 : 4'b0000, pack4(64'd0, 64'd0, 64'd7, 64'd0), (i < 3));
      acks += (clr_ack === 1'b1) ? 1 : 0;
      vectors++;
      if (req_ready !== e_ready || accum_a !== e_a || resp_valid !== e_rv || clr_ack !== e_ack ||
          op_count !== e_cnt || accum_x !== e_x || (e_rv && (resp_id !== e_rid || resp_data !== e_x))) begin
        miscompares++;
        $display("FAIL clear %0d: rdy=%b a=%h rv=%b id=%0d rd=%h ack=%b cnt=%0d x=%h, expected rdy=%b a=%h rv=%b id=%0d rd=%h ack=%b cnt=%0d x=%h",
                 i, req_ready, accum_a, resp_valid, resp_id, resp_data, clr_ack, op_count, accum_x,
                 e_ready, e_a, e_rv, e_rid, e_x, e_ack, e_cnt, e_x);
      end
      if (i == 0) begin
        vectors++;
        if (accum_a !== ~64'd20 || req_ready !== '0) begin
          miscompares++;
          $display("FAIL clear_operand: a=%h rdy=%b, expected a=%h rdy=0", accum_a, req_ready, ~64'd20);
        end
      end
      if (i == 1) begin
        vectors++;
        if (clr_ack !== 1'b1 || accum_x !== 64'd0 || req_ready !== 4'b0100) begin
          miscompares++;
          $display("FAIL clear_done: ack=%b x=%h rdy=%b, expected ack=1 x=0 rdy=0100", clr_ack, accum_x, req_ready);
        end
      end
      if (i == 2) begin
        vectors++;
        if (resp_valid !== 1'b1 || resp_id !== 2'd2 || resp_data !== 64'd7) begin
          miscompares++;
          $display("FAIL clear_resp: rv=%b id=%0d rd=%0d, expected rv=1 id=2 rd=7", resp_valid, resp_id, resp_data);
        end
      end
      commit();
    end
    vectors++;
    if (acks != 1) begin
      miscompares++;
      $display("FAIL clear_ack_count: %0d acks, expected 1", acks);
    end
  endtask

  task automatic test_wrap();
    drive('0, '0, 1'b1); commit();
    drive('0, '0, 1'b0); commit();
    drive(4'b0001, pack4(64'hFFFF_FFFF_FFFF_FFFE, 64'd0, 64'd0, 64'd0), 1'b0); commit();
    for (int i = 0; i < 3; i++) begin
      case (i)
        0:       drive(4'b0010, pack4(64'd0, 64'd3, 64'd0, 64'd0), 1'b0);
        1:       drive(4'b0100, pack4(64'd0, 64'd0, 64'd0, 64'd0), 1'b0);
        default: drive(4'b0000, '0, 1'b0);
      endcase
      vectors++;
      if (req_ready !== e_ready || accum_a !== e_a || resp_valid !== e_rv || clr_ack !== e_ack ||
          op_count !== e_cnt || accum_x !== e_x || (e_rv && (resp_id !== e_rid || resp_data !== e_x))) begin
        miscompares++;
        $display("FAIL wrap %0d: rdy=%b a=%h rv=%b id=%0d rd=%h ack=%b cnt=%0d x=%h, expected rdy=%b a=%h rv=%b id=%0d rd=%h ack=%b cnt=%0d x=%h",
                 i, req_ready, accum_a, resp_valid, resp_id, resp_data, clr_ack, op_count, accum_x,
                 e_ready, e_a, e_rv, e_rid, e_x, e_ack, e_cnt, e_x);
      end
      if (i > 0) begin
        vectors++;
        if (resp_valid !== 1'b1 || resp_data !== 64'd1 || (i == 1 && accum_a !== '1)) begin
          miscompares++;
          $display("FAIL wrap_value %0d: rv=%b rd=%h a=%h, expected rv=1 rd=1", i, resp_valid, resp_data, accum_a);
        end
      end
      commit();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive(NUM_REQ'($urandom), pack4(rnd64(), rnd64(), rnd64(), rnd64()), ($urandom % 10) == 0);
      vectors++;
      if (req_ready !== e_ready || accum_a !== e_a || resp_valid !== e_rv || clr_ack !== e_ack ||
          op_count !== e_cnt || accum_x !== e_x || (e_rv && (resp_id !== e_rid || resp_data !== e_x))) begin
        miscompares++;
        $display("FAIL random %0d: rdy=%b a=%h rv=%b id=%0d rd=%h ack=%b cnt=%0d x=%h, expected rdy=%b a=%h rv=%b id=%0d rd=%h ack=%b cnt=%0d x=%h",
                 i, req_ready, accum_a, resp_valid, resp_id, resp_data, clr_ack, op_count, accum_x,
                 e_ready, e_a, e_rv, e_rid, e_x, e_ack, e_cnt, e_x);
      end
      commit();
    end
    vectors++;
    if (op_count !== CNT_W'(CNT_MAX)) begin
      miscompares++;
      $display("FAIL saturation: cnt=%0d, expected %0d", op_count, CNT_MAX);
    end
  endtask

  task automatic test_reset_mid();
    drive(4'b1000, pack4(64'd0, 64'd0, 64'd0, 64'd11), 1'b0);
    commit();
    rst_n = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      req_valid = '1; req_data = pack4(rnd64(), rnd64(), rnd64(), rnd64()); clr_req = 1'b1;
      @(negedge clk);
      vectors++;
      if (req_ready !== '0 || accum_a !== '1 || resp_valid !== 1'b0 || clr_ack !== 1'b0 ||
          op_count !== '0 || accum_x !== m_acc) begin
        miscompares++;
        $display("FAIL reset_mid %0d: rdy=%b a=%h rv=%b ack=%b cnt=%0d x=%h, expected rdy=0 a=all-ones rv=0 ack=0 cnt=0 x=%h",
                 i, req_ready, accum_a, resp_valid, clr_ack, op_count, accum_x, m_acc);
      end
      @(posedge clk);
      #1;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      if (i == 0) drive('1, pack4(rnd64(), rnd64(), rnd64(), rnd64()), 1'b0);
      else        drive('0, '0, 1'b0);
      vectors++;
      if (req_ready !== e_ready || accum_a !== e_a || resp_valid !== e_rv || clr_ack !== e_ack ||
          op_count !== e_cnt || accum_x !== e_x || (e_rv && (resp_id !== e_rid || resp_data !== e_x)) ||
          (i == 0 && req_ready !== 4'b0001)) begin
        miscompares++;
        $display("FAIL after_reset %0d: rdy=%b a=%h rv=%b id=%0d rd=%h ack=%b cnt=%0d x=%h, expected rdy=%b a=%h rv=%b id=%0d rd=%h ack=%b cnt=%0d x=%h",
                 i, req_ready, accum_a, resp_valid, resp_id, resp_data, clr_ack, op_count, accum_x,
                 e_ready, e_a, e_rv, e_rid, e_x, e_ack, e_cnt, e_x);
      end
      commit();
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_idle();
    test_clear();
    test_wrap();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
